// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access-width codes,
// FSM state encoding and the legality/alignment check.
package mem_lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } lsu_state_t;

   // True when the access can never reach memory: unknown width, a 64-bit-only
   // width on a 32-bit datapath, or an address not aligned to the access size.
   function automatic logic access_fault(input logic [2:0] funct3,
                                         input logic [2:0] addr_lo,
                                         input logic       wide);
      logic fault;
      fault = 1'b0;
      case (funct3)
         F3_B, F3_BU: fault = 1'b0;
         F3_H, F3_HU: fault = addr_lo[0];
         F3_W:        fault = |addr_lo[1:0];
         F3_WU:       fault = ~wide | (|addr_lo[1:0]);
         F3_D:        fault = ~wide | (|addr_lo);
         default:     fault = 1'b1;
      endcase
      return fault;
   endfunction

endpackage

// File: rtl/mem_lsu_stage_align.sv
// Byte-lane steering: replicates store data across the bus with byte enables,
// and pulls a load value out of its lane with sign or zero extension.
module lsu_align
   import mem_lsu_pkg::*;
#(
   parameter  int XLEN   = 32,
   localparam int NBYTES = XLEN / 8,
   localparam int LANE_W = $clog2(NBYTES)
) (
   input  logic [2:0]        funct3,
   input  logic [LANE_W-1:0] lane,
   input  logic [XLEN-1:0]   store_data,
   input  logic [XLEN-1:0]   load_data,
   output logic [XLEN-1:0]   wdata,
   output logic [NBYTES-1:0] be,
   output logic [XLEN-1:0]   load_value
);

   logic [LANE_W-1:0] lane_h;
   logic [LANE_W-1:0] lane_w;
   logic [XLEN-1:0]   shifted;
   logic [XLEN-1:0]   mask;
   logic              sign;

   assign lane_h = lane & ~LANE_W'(1);
   assign lane_w = lane & ~LANE_W'(3);

   always_comb begin
      wdata = store_data;
      be    = '1;
      case (funct3[1:0])
         2'b00: begin
            wdata = {NBYTES{store_data[7:0]}};
            be    = NBYTES'(1) << lane;
         end
         2'b01: begin
            wdata = {(NBYTES/2){store_data[15:0]}};
            be    = NBYTES'(3) << lane_h;
         end
         2'b10: begin
            wdata = {(NBYTES/4){store_data[31:0]}};
            be    = NBYTES'(15) << lane_w;
         end
         default: begin
            wdata = store_data;
            be    = '1;
         end
      endcase
   end

   // Extension is done by masking rather than concatenation so the same code
   // covers a full-width word on a 32-bit bus without a zero-count replicate.
   always_comb begin
      shifted = load_data >> {lane, 3'b000};
      mask    = '1;
      sign    = 1'b0;
      case (funct3[1:0])
         2'b00: begin
            mask = XLEN'(8'hFF);
            sign = shifted[7];
         end
         2'b01: begin
            mask = XLEN'(16'hFFFF);
            sign = shifted[15];
         end
         2'b10: begin
            mask = XLEN'(32'hFFFF_FFFF);
            sign = shifted[31];
         end
         default: begin
            mask = '1;
            sign = 1'b0;
         end
      endcase
      load_value = (shifted & mask) | ((~funct3[2] & sign) ? ~mask : '0);
   end

endmodule

// File: rtl/mem_lsu_stage.sv
// MEM pipeline stage: issues data-memory requests through a small handshake
// FSM, stalls upstream until the access finishes, and holds the MEM/WB register.
module mem_lsu_stage
   import mem_lsu_pkg::*;
#(
   parameter  int XLEN   = 32,
   localparam int NBYTES = XLEN / 8,
   localparam int LANE_W = $clog2(NBYTES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              mem_we,
   input  logic              mem_re,
   input  logic [2:0]        funct3,
   input  logic [XLEN-1:0]   alu_out,
   input  logic [XLEN-1:0]   reg_out_b,
   input  logic              branch_instruction,
   input  logic              branch_in,
   input  logic              reg_file_write_in,
   input  logic [XLEN-1:0]   add_pc_in,
   input  logic [1:0]        select_mux_2_in,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [XLEN-1:0]   dmem_addr,
   output logic [XLEN-1:0]   dmem_wdata,
   output logic [NBYTES-1:0] dmem_be,
   input  logic              dmem_ready,
   input  logic              dmem_rvalid,
   input  logic [XLEN-1:0]   dmem_rdata,
   output logic              stall_out,
   output logic [1:0]        select_mux_3_out,
   output logic              wb_valid,
   output logic              reg_file_write_out,
   output logic              lsu_fault,
   output logic [XLEN-1:0]   mem_out,
   output logic [XLEN-1:0]   alu_result_out,
   output logic [XLEN-1:0]   add_pc_out,
   output logic [1:0]        select_mux_2_out
);

   localparam logic WIDE = (XLEN == 64);

   lsu_state_t        state;
   lsu_state_t        state_next;
   logic              mem_op;
   logic              fault;
   logic              legal_op;
   logic              issue;
   logic              complete;
   logic              load_done;
   logic [XLEN-1:0]   fmt_wdata;
   logic [NBYTES-1:0] fmt_be;
   logic [XLEN-1:0]   load_value;

   assign mem_op   = in_valid & (mem_re | mem_we);
   assign fault    = mem_op & access_fault(funct3, alu_out[2:0], WIDE);
   assign legal_op = mem_op & ~fault;

   lsu_align #(.XLEN(XLEN)) u_align (
      .funct3     (funct3),
      .lane       (alu_out[LANE_W-1:0]),
      .store_data (reg_out_b),
      .load_data  (dmem_rdata),
      .wdata      (fmt_wdata),
      .be         (fmt_be),
      .load_value (load_value)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // mem_we wins over mem_re, so "store" below is simply mem_we.
   always_comb begin
      state_next = state;
      issue      = 1'b0;
      complete   = 1'b0;
      load_done  = 1'b0;
      case (state)
         IDLE: begin
            if (legal_op) begin
               issue = 1'b1;
               if (dmem_ready) begin
                  if (mem_we) begin
                     complete = 1'b1;
                  end else begin
                     state_next = WAIT;
                  end
               end else begin
                  state_next = REQ;
               end
            end else begin
               complete = in_valid;
            end
         end
         REQ: begin
            issue = 1'b1;
            if (dmem_ready) begin
               if (mem_we) begin
                  complete   = 1'b1;
                  state_next = IDLE;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (dmem_rvalid) begin
               complete   = 1'b1;
               load_done  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Request fields come straight from the held upstream inputs, which is what
   // keeps them stable across REQ cycles.
   assign dmem_req         = issue & reset;
   assign dmem_we          = dmem_req & mem_we;
   assign dmem_addr        = {alu_out[XLEN-1:LANE_W], {LANE_W{1'b0}}};
   assign dmem_wdata       = fmt_wdata;
   assign dmem_be          = dmem_req ? fmt_be : '0;
   assign stall_out        = in_valid & ~complete;
   assign select_mux_3_out = {1'b0, in_valid & branch_instruction & branch_in};

   always_ff @(posedge clk) begin
      if (!reset) begin
         wb_valid           <= 1'b0;
         reg_file_write_out <= 1'b0;
         lsu_fault          <= 1'b0;
         mem_out            <= '0;
         alu_result_out     <= '0;
         add_pc_out         <= '0;
         select_mux_2_out   <= '0;
      end else if (complete) begin
         wb_valid           <= 1'b1;
         reg_file_write_out <= reg_file_write_in & ~fault;
         lsu_fault          <= fault;
         mem_out            <= load_done ? load_value : '0;
         alu_result_out     <= alu_out;
         add_pc_out         <= add_pc_in;
         select_mux_2_out   <= select_mux_2_in;
      end else begin
         wb_valid           <= 1'b0;
         reg_file_write_out <= 1'b0;
         lsu_fault          <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Randomised and directed checks of mem_lsu_stage against a transaction-level
// model of the memory stage; a second 64-bit instance covers the wide widths.
module tb_mem_lsu_stage;

   logic        clk = 1'b0;
   logic        reset;
   always #5 clk = ~clk;

   logic        in_valid, mem_we, mem_re, branch_instruction, branch_in, reg_file_write_in;
   logic [2:0]  funct3;
   logic [31:0] alu_out, reg_out_b, add_pc_in, dmem_rdata;
   logic [1:0]  select_mux_2_in;
   logic        dmem_ready, dmem_rvalid;
   logic        dmem_req, dmem_we, stall_out, wb_valid, reg_file_write_out, lsu_fault;
   logic [31:0] dmem_addr, dmem_wdata, mem_out, alu_result_out, add_pc_out;
   logic [3:0]  dmem_be;
   logic [1:0]  select_mux_3_out, select_mux_2_out;

   logic        w_in_valid, w_mem_we, w_mem_re;
   logic [2:0]  w_funct3;
   logic [63:0] w_alu_out, w_reg_out_b, w_dmem_rdata;
   logic        w_dmem_ready, w_dmem_rvalid;
   logic        w_dmem_req, w_dmem_we, w_stall_out, w_wb_valid, w_rfw_out, w_lsu_fault;
   logic [63:0] w_dmem_addr, w_dmem_wdata, w_mem_out, w_alu_result_out, w_add_pc_out;
   logic [7:0]  w_dmem_be;
   logic [1:0]  w_sm3_out, w_sm2_out;

   mem_lsu_stage u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .mem_we(mem_we), .mem_re(mem_re),
      .funct3(funct3), .alu_out(alu_out), .reg_out_b(reg_out_b),
      .branch_instruction(branch_instruction), .branch_in(branch_in),
      .reg_file_write_in(reg_file_write_in), .add_pc_in(add_pc_in),
      .select_mux_2_in(select_mux_2_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .stall_out(stall_out), .select_mux_3_out(select_mux_3_out), .wb_valid(wb_valid),
      .reg_file_write_out(reg_file_write_out), .lsu_fault(lsu_fault), .mem_out(mem_out),
      .alu_result_out(alu_result_out), .add_pc_out(add_pc_out),
      .select_mux_2_out(select_mux_2_out)
   );

   mem_lsu_stage #(.XLEN(64)) u_dut64 (
      .clk(clk), .reset(reset), .in_valid(w_in_valid), .mem_we(w_mem_we), .mem_re(w_mem_re),
      .funct3(w_funct3), .alu_out(w_alu_out), .reg_out_b(w_reg_out_b),
      .branch_instruction(1'b0), .branch_in(1'b0), .reg_file_write_in(1'b1),
      .add_pc_in(64'h0), .select_mux_2_in(2'b00), .dmem_req(w_dmem_req), .dmem_we(w_dmem_we),
      .dmem_addr(w_dmem_addr), .dmem_wdata(w_dmem_wdata), .dmem_be(w_dmem_be),
      .dmem_ready(w_dmem_ready), .dmem_rvalid(w_dmem_rvalid), .dmem_rdata(w_dmem_rdata),
      .stall_out(w_stall_out), .select_mux_3_out(w_sm3_out), .wb_valid(w_wb_valid),
      .reg_file_write_out(w_rfw_out), .lsu_fault(w_lsu_fault), .mem_out(w_mem_out),
      .alu_result_out(w_alu_result_out), .add_pc_out(w_add_pc_out),
      .select_mux_2_out(w_sm2_out)
   );

   int checks = 0;
   int errors = 0;
   int stall_seen = 0;
   int req_seen = 0;

   bit          chk_en, chk_comb, chk_reg;
   logic        exp_req, exp_we, exp_stall;
   logic [1:0]  exp_sm3;
   logic [31:0] exp_addr, exp_wdata;
   logic [3:0]  exp_be;
   logic        e_wb_valid, e_rfw, e_fault;
   logic [31:0] e_mem_out, e_alu, e_pc;
   logic [1:0]  e_sm2;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model of a 32-bit access.
   function automatic int m_size(input logic [2:0] f3);
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         3'd2:       return 4;
         default:    return 0;
      endcase
   endfunction

   function automatic bit m_fault(input logic [2:0] f3, input logic [31:0] a);
      int sz = m_size(f3);
      return (sz == 0) || ((a % sz) != 0);
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
      logic [3:0] be = 4'b0;
      int sz = m_size(f3);
      for (int i = 0; i < sz; i++) be[(a % 4) + i] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] w = 32'h0;
      int sz = m_size(f3);
      if (sz == 0) return 32'h0;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
      int sz = m_size(f3);
      logic [31:0] v = rd >> (8 * (a % 4));
      logic top = v[8*sz-1];
      for (int k = 8 * sz; k < 32; k++) v[k] = f3[2] ? 1'b0 : top;
      return v;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         if (stall_out === 1'b1) stall_seen++;
         if (dmem_req === 1'b1) req_seen++;
         checkOutput("dmem_req", dmem_req, exp_req);
         if (chk_comb) begin
            checkOutput("select_mux_3_out", select_mux_3_out, exp_sm3);
            checkOutput("stall_out", stall_out, exp_stall);
            if (exp_req) begin
               checkOutput("dmem_we", dmem_we, exp_we);
               checkOutput("dmem_addr", dmem_addr, exp_addr);
               checkOutput("dmem_wdata", dmem_wdata, exp_wdata);
               checkOutput("dmem_be", dmem_be, exp_be);
            end
         end
         if (chk_reg) begin
            checkOutput("wb_valid", wb_valid, e_wb_valid);
            checkOutput("reg_file_write_out", reg_file_write_out, e_rfw);
            checkOutput("lsu_fault", lsu_fault, e_fault);
            checkOutput("mem_out", mem_out, e_mem_out);
            checkOutput("alu_result_out", alu_result_out, e_alu);
            checkOutput("add_pc_out", add_pc_out, e_pc);
            checkOutput("select_mux_2_out", select_mux_2_out, e_sm2);
         end
      end
   end

   // Drives one instruction for as many cycles as the stage needs, acting as
   // memory with r cycles of ready delay and w empty WAIT cycles for loads.
   task automatic applyStimulus(input bit iv, we, re, input logic [2:0] f3,
                                input logic [31:0] addr, data, input bit rfw, bi, bin,
                                input logic [31:0] pc, input logic [1:0] sm2,
                                input int r, w, input bit use_rd, input logic [31:0] rd);
      bit mem_op, flt, legal, load, issue, last;
      int nc;
      mem_op = iv && (we || re);
      flt    = mem_op && m_fault(f3, addr);
      legal  = mem_op && !flt;
      load   = legal && !we;
      nc     = !legal ? 1 : (we ? r + 1 : r + w + 2);
      for (int c = 0; c < nc; c++) begin
         in_valid = iv; mem_we = we; mem_re = re; funct3 = f3; alu_out = addr;
         reg_out_b = data; reg_file_write_in = rfw; branch_instruction = bi;
         branch_in = bin; add_pc_in = pc; select_mux_2_in = sm2;
         issue = legal && (c <= r);
         last  = (c == nc - 1);
         dmem_ready  = issue ? (c == r) : 1'($urandom_range(0, 1));
         dmem_rvalid = (load && c > r) ? last : 1'($urandom_range(0, 1));
         dmem_rdata  = (use_rd && last) ? rd : $urandom;
         exp_req   = issue;
         exp_we    = we;
         exp_addr  = addr & ~32'h3;
         exp_wdata = m_wdata(f3, data);
         exp_be    = m_be(f3, addr);
         exp_stall = iv && !last;
         exp_sm3   = {1'b0, iv && bi && bin};
         chk_comb  = 1'b1;
         @(posedge clk);
         #1;
         if (last && iv) begin
            e_wb_valid = 1'b1; e_rfw = rfw && !flt; e_fault = flt;
            e_mem_out  = load ? m_load(f3, addr, dmem_rdata) : 32'h0;
            e_alu = addr; e_pc = pc; e_sm2 = sm2;
         end else begin
            e_wb_valid = 1'b0; e_rfw = 1'b0; e_fault = 1'b0;
         end
      end
      in_valid = 1'b0; dmem_ready = 1'b0; dmem_rvalid = 1'b0;
      exp_req = 1'b0; exp_stall = 1'b0; exp_sm3 = 2'b00;
   endtask

   task automatic tick_bubble();
      @(posedge clk);
      #1;
      e_wb_valid = 1'b0; e_rfw = 1'b0; e_fault = 1'b0;
   endtask

   initial begin
      int s0, q0;
      bit we, re;
      logic [31:0] a;
      logic [2:0] f3;
      reset = 1'b0;
      chk_en = 1'b1; chk_comb = 1'b0; chk_reg = 1'b0;
      exp_req = 1'b0; exp_we = 1'b0; exp_stall = 1'b0; exp_sm3 = 2'b00;
      exp_addr = '0; exp_wdata = '0; exp_be = '0;
      in_valid = 1'b1; mem_we = 1'b1; mem_re = 1'b0; funct3 = 3'b010; alu_out = 32'h100;
      reg_out_b = 32'h1234; branch_instruction = 1'b0; branch_in = 1'b0;
      reg_file_write_in = 1'b1; add_pc_in = 32'h44; select_mux_2_in = 2'b01;
      dmem_ready = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      w_in_valid = 1'b0; w_mem_we = 1'b0; w_mem_re = 1'b0; w_funct3 = 3'b000;
      w_alu_out = '0; w_reg_out_b = '0; w_dmem_rdata = '0;
      w_dmem_ready = 1'b0; w_dmem_rvalid = 1'b0;

      @(posedge clk);
      #1;
      e_wb_valid = 1'b0; e_rfw = 1'b0; e_fault = 1'b0;
      e_mem_out = '0; e_alu = '0; e_pc = '0; e_sm2 = '0;
      chk_reg = 1'b1;
      tick_bubble();
      reset = 1'b1; in_valid = 1'b0; dmem_ready = 1'b0; dmem_rvalid = 1'b0;
      chk_comb = 1'b1;

      checkOutput("model_be_sb", m_be(3'd0, 32'h1003), 4'b1000);
      checkOutput("model_wdata_sb", m_wdata(3'd0, 32'hAABBCCDD), 32'hDDDDDDDD);
      checkOutput("model_wdata_sh", m_wdata(3'd1, 32'hAABBCCDD), 32'hCCDDCCDD);
      checkOutput("model_lb", m_load(3'd0, 32'h2001, 32'h0000_8000), 32'hFFFFFF80);
      checkOutput("model_lhu", m_load(3'd5, 32'h2002, 32'h8001_0000), 32'h0000_8001);

      s0 = stall_seen;
      applyStimulus(1, 1, 0, 3'd0, 32'h1003, 32'hAABBCCDD, 1, 0, 0, 32'h10, 2'd1, 0, 0, 0, 0);
      #2;
      checkOutput("sb_stall_cycles", stall_seen - s0, 0);
      checkOutput("sb_wb_valid", wb_valid, 1'b1);

      s0 = stall_seen;
      applyStimulus(1, 0, 1, 3'd0, 32'h2001, 32'h0, 1, 1, 1, 32'h20, 2'd2, 0, 3, 1, 32'h0000_8000);
      #2;
      checkOutput("lb_stall_cycles", stall_seen - s0, 4);
      checkOutput("lb_mem_out", mem_out, 32'hFFFFFF80);
      applyStimulus(1, 0, 1, 3'd4, 32'h2001, 32'h0, 1, 0, 1, 32'h24, 2'd2, 1, 2, 1, 32'h0000_8000);
      #2;
      checkOutput("lbu_mem_out", mem_out, 32'h00000080);

      s0 = stall_seen; q0 = req_seen;
      applyStimulus(1, 0, 1, 3'd2, 32'h2002, 32'h0, 1, 0, 0, 32'h28, 2'd3, 0, 0, 0, 0);
      #2;
      checkOutput("lw_mis_req_count", req_seen - q0, 0);
      checkOutput("lw_mis_stall_cycles", stall_seen - s0, 0);
      checkOutput("lw_mis_fault", lsu_fault, 1'b1);
      checkOutput("lw_mis_rfw", reg_file_write_out, 1'b0);

      s0 = stall_seen;
      applyStimulus(1, 1, 1, 3'd2, 32'h4008, 32'h5566_7788, 0, 0, 0, 32'h30, 2'd0, 5, 0, 0, 0);
      #2;
      checkOutput("sw_wait_stall_cycles", stall_seen - s0, 5);
      checkOutput("sw_wait_wb_valid", wb_valid, 1'b1);

      // 64-bit instance, driven by hand while the 32-bit one idles.
      w_in_valid = 1'b1; w_mem_re = 1'b1; w_funct3 = 3'b110; w_alu_out = 64'h10004;
      w_dmem_ready = 1'b1;
      #2;
      checkOutput("x64_lwu_req", w_dmem_req, 1'b1);
      checkOutput("x64_lwu_be", w_dmem_be, 8'hF0);
      checkOutput("x64_lwu_addr", w_dmem_addr, 64'h10000);
      tick_bubble();
      w_dmem_ready = 1'b0; w_dmem_rvalid = 1'b1; w_dmem_rdata = 64'hF0000000_00000000;
      #2;
      checkOutput("x64_lwu_stall", w_stall_out, 1'b0);
      tick_bubble();
      w_funct3 = 3'b010; w_dmem_ready = 1'b1; w_dmem_rvalid = 1'b0;
      #2;
      checkOutput("x64_lwu_mem_out", w_mem_out, 64'h00000000_F0000000);
      tick_bubble();
      w_dmem_ready = 1'b0; w_dmem_rvalid = 1'b1;
      tick_bubble();
      w_mem_re = 1'b0; w_mem_we = 1'b1; w_funct3 = 3'b011; w_alu_out = 64'h10008;
      w_reg_out_b = 64'h11223344_55667788; w_dmem_ready = 1'b1; w_dmem_rvalid = 1'b0;
      #2;
      checkOutput("x64_lw_mem_out", w_mem_out, 64'hFFFFFFFF_F0000000);
      checkOutput("x64_sd_be", w_dmem_be, 8'hFF);
      checkOutput("x64_sd_wdata", w_dmem_wdata, 64'h11223344_55667788);
      tick_bubble();
      w_in_valid = 1'b0; w_dmem_ready = 1'b0;
      #2;
      checkOutput("x64_sd_wb_valid", w_wb_valid, 1'b1);

      // Reset while a load sits in WAIT; the late rvalid must be dropped.
      in_valid = 1'b1; mem_we = 1'b0; mem_re = 1'b1; funct3 = 3'd2; alu_out = 32'h3000;
      reg_file_write_in = 1'b1; branch_instruction = 1'b0;
      dmem_ready = 1'b1; dmem_rvalid = 1'b0;
      exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h3000; exp_be = 4'hF;
      exp_wdata = m_wdata(3'd2, reg_out_b); exp_stall = 1'b1; exp_sm3 = 2'b00;
      tick_bubble();
      dmem_ready = 1'b0; exp_req = 1'b0;
      tick_bubble();
      reset = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h1357_9BDF; chk_comb = 1'b0;
      @(posedge clk);
      #1;
      e_wb_valid = 1'b0; e_rfw = 1'b0; e_fault = 1'b0;
      e_mem_out = '0; e_alu = '0; e_pc = '0; e_sm2 = '0;
      reset = 1'b1; in_valid = 1'b0; exp_stall = 1'b0; chk_comb = 1'b1;
      tick_bubble();
      dmem_rvalid = 1'b0;
      checkOutput("rst_wait_wb_valid", wb_valid, 1'b0);
      checkOutput("rst_wait_mem_out", mem_out, 32'h0);
      s0 = stall_seen;
      applyStimulus(1, 0, 1, 3'd5, 32'h3002, 32'h0, 1, 0, 0, 32'h50, 2'd1, 2, 1, 1, 32'h8001_0000);
      #2;
      checkOutput("after_rst_stall_cycles", stall_seen - s0, 4);
      checkOutput("after_rst_lhu", mem_out, 32'h0000_8001);

      for (int t = 0; t < 300; t++) begin
         we = 1'($urandom_range(0, 1));
         re = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) a = a & ~32'h7;
         applyStimulus(($urandom_range(0, 7) != 0), we, re, f3, a, $urandom,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
                       $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
